// File: rtl/fp_div_pkg.sv
// Shared state type, flag positions and encoding helpers for the floating-point divider.
// Helpers take the field widths as arguments so any instance can size its constants.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam int unsigned FP_MAX_W = 64;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                    input int unsigned man_w);
        logic [FP_MAX_W-1:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic        sign,
                                                   input int unsigned exp_w,
                                                   input int unsigned man_w);
        logic [FP_MAX_W-1:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        if (sign) begin
            v = v | (64'd1 << (exp_w + man_w));
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_div_seq_round_pack.sv
// Combinational normalise, round-to-nearest-even and pack for a quotient in [0.5,2).
// Overflow saturates to signed infinity, underflow flushes to signed zero.
module fp_round_pack
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                      i_sign,
    input  logic signed [EXP_W+1:0]   i_exp,
    input  logic [MAN_W+2:0]          i_quo,
    input  logic                      i_sticky,
    output logic [EXP_W+MAN_W:0]      o_bits,
    output logic                      o_of,
    output logic                      o_uf,
    output logic                      o_nx
);
    localparam int unsigned W = EXP_W + MAN_W + 1;
    localparam logic [W-1:0] INF = W'(fp_inf(1'b0, EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] EXP_ONE = $signed({{(EXP_W+1){1'b0}}, 1'b1});
    localparam logic signed [EXP_W+1:0] EXP_MAX = $signed((EXP_W+2)'((32'd1 << EXP_W) - 32'd1));

    logic [MAN_W+2:0]        w_norm;
    logic signed [EXP_W+1:0] w_exp_n;
    logic signed [EXP_W+1:0] w_exp_r;
    logic                    w_guard;
    logic                    w_rnd;
    logic                    w_up;
    logic                    w_inexact;
    logic [MAN_W+1:0]        w_mant;
    logic [MAN_W-1:0]        w_frac;

    always_comb begin
        w_norm  = i_quo[MAN_W+2] ? i_quo : {i_quo[MAN_W+1:0], 1'b0};
        w_exp_n = i_quo[MAN_W+2] ? i_exp : (i_exp - EXP_ONE);

        w_guard   = w_norm[1];
        w_rnd     = w_norm[0];
        w_inexact = w_guard | w_rnd | i_sticky;
        w_up      = w_guard & (w_rnd | i_sticky | w_norm[2]);
        w_mant    = {1'b0, w_norm[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, w_up};

        // Carry out of rounding leaves 1.000..., so the fraction is just the shifted field.
        if (w_mant[MAN_W+1]) begin
            w_frac  = w_mant[MAN_W:1];
            w_exp_r = w_exp_n + EXP_ONE;
        end else begin
            w_frac  = w_mant[MAN_W-1:0];
            w_exp_r = w_exp_n;
        end

        o_of   = 1'b0;
        o_uf   = 1'b0;
        o_bits = {i_sign, w_exp_r[EXP_W-1:0], w_frac};
        if (!w_exp_r[EXP_W+1] && (w_exp_r >= EXP_MAX)) begin
            o_of   = 1'b1;
            o_bits = {i_sign, INF[W-2:0]};
        end else if (w_exp_r[EXP_W+1] || (w_exp_r == '0)) begin
            o_uf   = 1'b1;
            o_bits = {i_sign, {(W-1){1'b0}}};
        end
        o_nx = w_inexact | o_of | o_uf;
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: restoring radix-2 quotient one bit per cycle, then a
// single round/pack cycle, with valid/ready handshakes on input and output.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);
    localparam int unsigned W     = EXP_W + MAN_W + 1;
    localparam int unsigned ITERS = MAN_W + 3;
    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0] INF  = W'(fp_inf(1'b0, EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] BIAS = $signed((EXP_W+2)'(fp_bias(EXP_W)));

    div_state_t              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sign;
    logic [EXP_W-1:0]        r_exp_a;
    logic [EXP_W-1:0]        r_exp_b;
    logic [MAN_W:0]          r_man_b;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W+2:0]        r_quo;
    logic                    r_special;
    logic [W-1:0]            r_spec_res;
    logic [4:0]              r_spec_flags;
    logic [W-1:0]            r_result;
    logic [4:0]              r_flags;

    logic [EXP_W-1:0]        w_ea;
    logic [EXP_W-1:0]        w_eb;
    logic [MAN_W-1:0]        w_fa;
    logic [MAN_W-1:0]        w_fb;
    logic                    w_sign;
    logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                    w_spec;
    logic [W-1:0]            w_spec_res;
    logic [4:0]              w_spec_flags;
    logic                    w_ge;
    logic [MAN_W+1:0]        w_rem_next;
    logic signed [EXP_W+1:0] w_exp;
    logic                    w_sticky;
    logic [W-1:0]            w_rp_bits;
    logic                    w_rp_of, w_rp_uf, w_rp_nx;
    logic [4:0]              w_rp_flags;

    assign w_ea     = a[W-2:MAN_W];
    assign w_eb     = b[W-2:MAN_W];
    assign w_fa     = a[MAN_W-1:0];
    assign w_fb     = b[MAN_W-1:0];
    assign w_sign   = a[W-1] ^ b[W-1];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);

    // Zero exponent covers subnormals too, so they fall into the signed-zero cases.
    always_comb begin
        w_spec       = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res            = QNAN;
            w_spec_flags[FLAG_NV] = 1'b1;
        end else if (w_b_zero && !w_a_inf) begin
            w_spec_res            = {w_sign, INF[W-2:0]};
            w_spec_flags[FLAG_DZ] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, INF[W-2:0]};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    assign w_ge       = (r_rem >= {1'b0, r_man_b});
    assign w_rem_next = (w_ge ? (r_rem - {1'b0, r_man_b}) : r_rem) << 1;
    assign w_exp      = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b}) + BIAS;
    assign w_sticky   = (r_rem != '0);

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign   (r_sign),
        .i_exp    (w_exp),
        .i_quo    (r_quo),
        .i_sticky (w_sticky),
        .o_bits   (w_rp_bits),
        .o_of     (w_rp_of),
        .o_uf     (w_rp_uf),
        .o_nx     (w_rp_nx)
    );

    always_comb begin
        w_rp_flags          = '0;
        w_rp_flags[FLAG_OF] = w_rp_of;
        w_rp_flags[FLAG_UF] = w_rp_uf;
        w_rp_flags[FLAG_NX] = w_rp_nx;
    end

    // Special operands skip DIV and go straight to ROUND, which registers the
    // precomputed answer, giving them a one-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_exp_a      <= '0;
            r_exp_b      <= '0;
            r_man_b      <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_special    <= 1'b0;
            r_spec_res   <= '0;
            r_spec_flags <= '0;
            r_result     <= '0;
            r_flags      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign       <= w_sign;
                        r_exp_a      <= w_ea;
                        r_exp_b      <= w_eb;
                        r_rem        <= {2'b01, w_fa};
                        r_man_b      <= {1'b1, w_fb};
                        r_quo        <= '0;
                        r_cnt        <= '0;
                        r_special    <= w_spec;
                        r_spec_res   <= w_spec_res;
                        r_spec_flags <= w_spec_flags;
                        r_state      <= w_spec ? ROUND : DIV;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[MAN_W+1:0], w_ge};
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ROUND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ROUND: begin
                    r_result <= r_special ? r_spec_res : w_rp_bits;
                    r_flags  <= r_special ? r_spec_flags : w_rp_flags;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases plus random binary32 operands
// checked against an integer long-division reference model.
module tb_fp_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    logic        h_in_valid;
    logic        h_in_ready;
    logic [15:0] h_a;
    logic [15:0] h_b;
    logic        h_out_valid;
    logic        h_out_ready;
    logic [15:0] h_result;
    logic [4:0]  h_flags;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .result    (h_result),
        .flags     (h_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact quotient via wide integer division, then RNE on the discarded bits.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [4:0] f,
                                    output bit special);
        logic s;
        int ex, ey, e, sh;
        logic [22:0] fx, fy;
        bit xz, yz, xi, yi, xn, yn, up, nx;
        longint unsigned mx, my, num, q, rem, kept, rest, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        special = 1'b1;
        f = 5'b00000;
        r = 32'h0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r = 32'h7FC00000;
            f = 5'b10000;
        end else if (yz && !xi) begin
            r = {s, 31'h7F800000};
            f = 5'b01000;
        end else if (xi) begin
            r = {s, 31'h7F800000};
        end else if (yi || xz) begin
            r = {s, 31'h0};
        end else begin
            special = 1'b0;
            mx  = 64'(fx) | (64'd1 << 23);
            my  = 64'(fy) | (64'd1 << 23);
            num = mx << 40;
            q   = num / my;
            rem = num % my;
            e   = ex - ey + 127;
            if (q < (64'd1 << 40)) begin
                sh = 39 - 23;
                e  = e - 1;
            end else begin
                sh = 40 - 23;
            end
            kept = q >> sh;
            rest = q & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            nx   = (rest != 0) || (rem != 0);
            up   = (rest > half) || ((rest == half) && ((rem != 0) || kept[0]));
            kept = kept + (up ? 64'd1 : 64'd0);
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e    = e + 1;
            end
            if (e >= 255) begin
                r = {s, 31'h7F800000};
                f = 5'b00101;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 5'b00011;
            end else begin
                r = {s, 8'(e), kept[22:0]};
                f = {4'b0000, nx};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int unsigned pick;
        pick = $urandom_range(0, 9);
        f = 23'($urandom);
        if (pick == 0) begin
            e = 8'h00;
        end else if (pick == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else if (pick == 2) begin
            e = 8'($urandom_range(1, 254));
            f = '0;
        end else if (pick <= 4) begin
            e = 8'($urandom_range(1, 254));
        end else begin
            e = 8'($urandom_range(100, 154));
        end
        return {1'($urandom), e, f};
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that completes the handshake.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b,
                          output logic [31:0] res, output logic [4:0] flg, output int lat);
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        op_a     = ta;
        op_b     = tb_b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_valid_seen", 64'(out_valid), 64'd1);
        res = result;
        flg = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic [4:0]  f;
        logic [31:0] er;
        logic [4:0]  ef;
        bit          sp;
        int          lat;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        h_in_valid  = 1'b0;
        h_out_ready = 1'b0;
        h_a         = '0;
        h_b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{32'h3FA00000, 32'h3F400000, 32'h3FD55555, 5'b00001, 27});
        vecs.push_back('{32'h411C0000, 32'hBF100000, 32'hC18AAAAB, 5'b00001, 27});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1});
        vecs.push_back('{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1});
        vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 5'b00101, 27});
        vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 5'b00011, 27});
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, r, f, lat);
            check_eq($sformatf("dir%0d_result", i), 64'(r), 64'(vecs[i].res));
            check_eq($sformatf("dir%0d_flags", i), 64'(f), 64'(vecs[i].flg));
            check_eq($sformatf("dir%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure: result held, inputs ignored while DONE waits on out_ready.
        op_a     = 32'h40C00000;
        op_b     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_latency", 64'(lat), 64'd27);
        check_eq("bp_result", 64'(result), 64'h40400000);
        check_eq("bp_flags", 64'(flags), 64'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk); #1;
            check_eq("bp_hold_result", 64'(result), 64'h40400000);
            check_eq("bp_hold_flags", 64'(flags), 64'd0);
            check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_out_valid", 64'(out_valid), 64'd0);
        check_eq("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of DIV.
        op_a     = 32'h3FA00000;
        op_b     = 32'h3F400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h3F800000, 32'h3F800000, r, f, lat);
        check_eq("post_rst_result", 64'(r), 64'h3F800000);
        check_eq("post_rst_flags", 64'(f), 64'd0);
        check_eq("post_rst_latency", 64'(lat), 64'd27);

        // Half-precision instance.
        check_eq("h_in_ready", 64'(h_in_ready), 64'd1);
        h_a        = 16'h3C00;
        h_b        = 16'h4000;
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("h_latency", 64'(lat), 64'd14);
        check_eq("h_result", 64'(h_result), 64'h3800);
        check_eq("h_flags", 64'(h_flags), 64'd0);
        h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_out_ready = 1'b0;
        check_eq("h_release_out_valid", 64'(h_out_valid), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = rand_fp();
            y = rand_fp();
            ref_div(x, y, er, ef, sp);
            run_op(x, y, r, f, lat);
            check_eq($sformatf("rnd_result %h/%h", x, y), 64'(r), 64'(er));
            check_eq($sformatf("rnd_flags %h/%h", x, y), 64'(f), 64'(ef));
            check_eq($sformatf("rnd_latency %h/%h", x, y), 64'(lat), sp ? 64'd1 : 64'd27);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
